morse_sequence_buffer: RTL and testbench

Parametrised storage for encoded Morse sequences. It sits after `sequence_separator` and replaces the fixed 16-entry `sequence_storage`. Each separator strobe can deliver up to two sequences (FirstSeq, SecSeq), and the block writes them in arrival order. It can optionally collapse redundant spaces and flags overflow. It keeps the flat storage bus and adds a valid/ready readout that drains the message on Enter.

---
 rtl/morse_sequence_buffer.sv | 165 ++++++++++++++++
 tb/tb_morse_sequence_buffer.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/morse_sequence_buffer.sv
// Ordered storage for encoded Morse sequences with optional space collapsing,
// overflow flagging and a valid/ready drain that is started by Enter.
module morse_sequence_buffer #(
    parameter int unsigned SYMS           = 5,
    parameter int unsigned DEPTH          = 16,
    parameter bit          COLLAPSE_SPACE = 1'b1
) (
    input  logic                         Clk,
    input  logic                         Resetbar,
    input  logic                         Clear,
    input  logic                         Enter,
    input  logic                         SentFlag,
    input  logic [2*SYMS-1:0]            FirstSeq,
    input  logic [2*SYMS-1:0]            SecSeq,
    output logic [DEPTH*2*SYMS-1:0]      o_sequence,
    output logic [2*SYMS-1:0]            OutSeq,
    output logic                         OutValid,
    input  logic                         OutReady,
    output logic [$clog2(DEPTH+1)-1:0]   Count,
    output logic                         Full,
    output logic                         Overflow,
    output logic                         Done
);

    localparam int unsigned SEQ_W = 2 * SYMS;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned IDX_W = $clog2(DEPTH);

    localparam logic [SEQ_W-1:0] INVALID_SEQ = '1;
    // Leading symbol 10 (space) followed by empty symbols.
    localparam logic [SEQ_W-1:0] SPACE_SEQ   = ~(SEQ_W'(1) << (SEQ_W - 2));

    typedef enum logic {
        ST_COLLECT = 1'b0,
        ST_DRAIN   = 1'b1
    } state_t;

    state_t                        state, state_next;
    logic [DEPTH-1:0][SEQ_W-1:0]   slots, slots_next, push_slots;
    logic [CNT_W-1:0]              count_next, rd_ptr, rd_next, wr_cnt;
    logic                          ovf_next, done_next, full_next;
    logic                          out_valid_next;
    logic [SEQ_W-1:0]              out_seq_next, cur;
    logic                          sent_prev, enter_prev;
    logic                          push_edge, enter_edge;
    logic                          last_space, keep, any_keep, push_ovf;

    assign o_sequence = slots;
    assign push_edge  = SentFlag & ~sent_prev;
    assign enter_edge = Enter & ~enter_prev;

    always_ff @(posedge Clk) begin
        if (!Resetbar) begin
            state      <= ST_COLLECT;
            slots      <= '1;
            Count      <= '0;
            rd_ptr     <= '0;
            Overflow   <= 1'b0;
            Done       <= 1'b0;
            Full       <= 1'b0;
            OutValid   <= 1'b0;
            OutSeq     <= '1;
            sent_prev  <= 1'b1;
            enter_prev <= 1'b1;
        end else begin
            state      <= state_next;
            slots      <= slots_next;
            Count      <= count_next;
            rd_ptr     <= rd_next;
            Overflow   <= ovf_next;
            Done       <= done_next;
            Full       <= full_next;
            OutValid   <= out_valid_next;
            OutSeq     <= out_seq_next;
            sent_prev  <= SentFlag;
            enter_prev <= Enter;
        end
    end

    // Candidate writes of FirstSeq then SecSeq; SecSeq sees FirstSeq's effect.
    always_comb begin
        push_slots = slots;
        wr_cnt     = Count;
        last_space = (Count != '0) && (slots[IDX_W'(Count - CNT_W'(1))] == SPACE_SEQ);
        any_keep   = 1'b0;
        push_ovf   = 1'b0;
        keep       = 1'b0;
        cur        = '1;
        for (int i = 0; i < 2; i++) begin
            cur  = (i == 0) ? FirstSeq : SecSeq;
            keep = (cur != INVALID_SEQ) &&
                   !(COLLAPSE_SPACE && (cur == SPACE_SEQ) && ((wr_cnt == '0) || last_space));
            if (keep) begin
                any_keep = 1'b1;
                if (wr_cnt < CNT_W'(DEPTH)) begin
                    push_slots[IDX_W'(wr_cnt)] = cur;
                    wr_cnt                     = wr_cnt + CNT_W'(1);
                    last_space                 = (cur == SPACE_SEQ);
                end else begin
                    push_ovf = 1'b1;
                end
            end
        end
    end

    always_comb begin
        state_next = state;
        slots_next = slots;
        count_next = Count;
        rd_next    = rd_ptr;
        ovf_next   = Overflow;
        done_next  = 1'b0;

        if (Clear) begin
            state_next = ST_COLLECT;
            slots_next = '1;
            count_next = '0;
            rd_next    = '0;
            ovf_next   = 1'b0;
        end else begin
            case (state)
                ST_COLLECT: begin
                    if (push_edge) begin
                        slots_next = push_slots;
                        count_next = wr_cnt;
                        if (push_ovf) begin
                            ovf_next = 1'b1;
                        end
                    end
                    // A same-cycle push is already part of count_next.
                    if (enter_edge) begin
                        if (count_next != '0) begin
                            state_next = ST_DRAIN;
                            rd_next    = '0;
                        end else begin
                            done_next = 1'b1;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (push_edge && any_keep) begin
                        ovf_next = 1'b1;
                    end
                    if (OutValid && OutReady) begin
                        if (rd_ptr == Count - CNT_W'(1)) begin
                            slots_next = '1;
                            count_next = '0;
                            rd_next    = '0;
                            done_next  = 1'b1;
                            state_next = ST_COLLECT;
                        end else begin
                            rd_next = rd_ptr + CNT_W'(1);
                        end
                    end
                end
                default: state_next = ST_COLLECT;
            endcase
        end

        full_next      = (count_next == CNT_W'(DEPTH));
        out_valid_next = (state_next == ST_DRAIN);
        out_seq_next   = out_valid_next ? slots_next[IDX_W'(rd_next)] : '1;
    end

endmodule

// File: tb/tb_morse_sequence_buffer.sv
// Bench for morse_sequence_buffer: three configurations share one stimulus
// stream and are compared every cycle against a queue-style reference model.
module tb_morse_sequence_buffer;

    localparam logic [9:0] A     = 10'b0001111111;
    localparam logic [9:0] THREE = 10'b0000000101;
    localparam logic [9:0] SP    = 10'b1011111111;
    localparam logic [9:0] INV   = 10'b1111111111;

    logic       clk = 1'b0;
    logic       Resetbar, Clear, Enter, SentFlag, OutReady;
    logic [9:0] FirstSeq, SecSeq;

    logic [159:0] seq0, seq1;
    logic [39:0]  seq2;
    logic [9:0]   oq0, oq1, oq2;
    logic         ov0, ov1, ov2, full0, full1, full2;
    logic         ovf0, ovf1, ovf2, done0, done1, done2;
    logic [4:0]   cnt0, cnt1;
    logic [2:0]   cnt2;

    int checks   = 0;
    int failures = 0;

    // Reference model state: per configuration a plain array used as a FIFO.
    int         dep[3] = '{16, 16, 4};
    bit         col[3] = '{1'b1, 1'b0, 1'b1};
    logic [9:0] mem[3][16];
    int         cnt[3];
    int         rd[3];
    bit         drain[3], ovf[3], dn[3];
    bit         sp_prev, en_prev;
    logic [159:0] ev;

    always #5 clk = ~clk;

    morse_sequence_buffer #(.SYMS(5), .DEPTH(16), .COLLAPSE_SPACE(1'b1)) u_c16 (
        .Clk(clk), .Resetbar(Resetbar), .Clear(Clear), .Enter(Enter), .SentFlag(SentFlag),
        .FirstSeq(FirstSeq), .SecSeq(SecSeq), .o_sequence(seq0), .OutSeq(oq0),
        .OutValid(ov0), .OutReady(OutReady), .Count(cnt0), .Full(full0),
        .Overflow(ovf0), .Done(done0));

    morse_sequence_buffer #(.SYMS(5), .DEPTH(16), .COLLAPSE_SPACE(1'b0)) u_n16 (
        .Clk(clk), .Resetbar(Resetbar), .Clear(Clear), .Enter(Enter), .SentFlag(SentFlag),
        .FirstSeq(FirstSeq), .SecSeq(SecSeq), .o_sequence(seq1), .OutSeq(oq1),
        .OutValid(ov1), .OutReady(OutReady), .Count(cnt1), .Full(full1),
        .Overflow(ovf1), .Done(done1));

    morse_sequence_buffer #(.SYMS(5), .DEPTH(4), .COLLAPSE_SPACE(1'b1)) u_c4 (
        .Clk(clk), .Resetbar(Resetbar), .Clear(Clear), .Enter(Enter), .SentFlag(SentFlag),
        .FirstSeq(FirstSeq), .SecSeq(SecSeq), .o_sequence(seq2), .OutSeq(oq2),
        .OutValid(ov2), .OutReady(OutReady), .Count(cnt2), .Full(full2),
        .Overflow(ovf2), .Done(done2));

    task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit stored(input int i, input logic [9:0] v);
        if (v == INV) return 1'b0;
        if (col[i] && v == SP && (cnt[i] == 0 || mem[i][cnt[i]-1] == SP)) return 1'b0;
        return 1'b1;
    endfunction

    task automatic model_edge();
        bit pe, ee;
        logic [9:0] s[2];
        pe = SentFlag && !sp_prev;
        ee = Enter && !en_prev;
        s[0] = FirstSeq;
        s[1] = SecSeq;
        for (int i = 0; i < 3; i++) begin
            dn[i] = 1'b0;
            if (!Resetbar || Clear) begin
                cnt[i] = 0; rd[i] = 0; drain[i] = 1'b0; ovf[i] = 1'b0;
            end else if (!drain[i]) begin
                if (pe) begin
                    for (int k = 0; k < 2; k++) begin
                        if (stored(i, s[k])) begin
                            if (cnt[i] < dep[i]) begin
                                mem[i][cnt[i]] = s[k];
                                cnt[i]++;
                            end else begin
                                ovf[i] = 1'b1;
                            end
                        end
                    end
                end
                if (ee) begin
                    if (cnt[i] > 0) begin drain[i] = 1'b1; rd[i] = 0; end
                    else dn[i] = 1'b1;
                end
            end else begin
                if (pe && (stored(i, s[0]) || stored(i, s[1]))) ovf[i] = 1'b1;
                if (OutReady) begin
                    if (rd[i] == cnt[i] - 1) begin
                        cnt[i] = 0; rd[i] = 0; drain[i] = 1'b0; dn[i] = 1'b1;
                    end else begin
                        rd[i]++;
                    end
                end
            end
        end
        if (!Resetbar) begin sp_prev = 1'b1; en_prev = 1'b1; end
        else begin sp_prev = SentFlag; en_prev = Enter; end
    endtask

    task automatic check_inst(input int i, input string nm, input logic [159:0] os,
                              input logic [9:0] oq, input logic ov, input logic [4:0] c,
                              input logic fl, input logic of, input logic d);
        logic [159:0] es;
        es = '0;
        for (int j = 0; j < dep[i]; j++) es[j*10 +: 10] = (j < cnt[i]) ? mem[i][j] : INV;
        chk({nm, ".o_sequence"}, os, es);
        chk({nm, ".OutSeq"}, 160'(oq), drain[i] ? 160'(mem[i][rd[i]]) : 160'(INV));
        chk({nm, ".OutValid"}, 160'(ov), 160'(drain[i]));
        chk({nm, ".Count"}, 160'(c), 160'(cnt[i]));
        chk({nm, ".Full"}, 160'(fl), 160'(cnt[i] == dep[i]));
        chk({nm, ".Overflow"}, 160'(of), 160'(ovf[i]));
        chk({nm, ".Done"}, 160'(d), 160'(dn[i]));
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_inst(0, "c16", seq0, oq0, ov0, cnt0, full0, ovf0, done0);
        check_inst(1, "n16", seq1, oq1, ov1, cnt1, full1, ovf1, done1);
        check_inst(2, "c4", {120'b0, seq2}, oq2, ov2, {2'b0, cnt2}, full2, ovf2, done2);
    endtask

    task automatic push(input logic [9:0] f, input logic [9:0] s);
        FirstSeq = f; SecSeq = s; SentFlag = 1'b1;
        step();
        SentFlag = 1'b0;
        step();
    endtask

    function automatic logic [9:0] pick();
        case ($urandom_range(0, 4))
            0:       return A;
            1:       return THREE;
            2:       return SP;
            3:       return INV;
            default: return 10'($urandom);
        endcase
    endfunction

    initial begin
        sp_prev = 1'b1; en_prev = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cnt[i] = 0; rd[i] = 0; drain[i] = 1'b0; ovf[i] = 1'b0; dn[i] = 1'b0;
        end
        Resetbar = 1'b0; Clear = 1'b0; Enter = 1'b0; SentFlag = 1'b0; OutReady = 1'b0;
        FirstSeq = INV; SecSeq = INV;
        step(); step();
        chk("reset_count", 160'(cnt0), 160'd0);
        chk("reset_outseq", 160'(oq0), 160'(INV));
        Resetbar = 1'b1;
        step();

        // Collapse on/off with identical pushes.
        push(A, SP); push(SP, INV); push(THREE, SP); push(THREE, SP);
        ev = '1;
        ev[59:0] = {SP, THREE, SP, THREE, SP, A};
        chk("s1_count", 160'(cnt0), 160'd6);
        chk("s1_slots", seq0, ev);
        chk("s1_overflow", 160'(ovf0), 160'd0);
        chk("s2_count", 160'(cnt1), 160'd7);

        // Drain with backpressure.
        Enter = 1'b1;
        step();
        chk("s3_valid", 160'(ov0), 160'd1);
        for (int k = 0; k < 8; k++) begin
            OutReady = (k == 1 || k == 4) ? 1'b0 : 1'b1;
            step();
        end
        chk("s3_done", 160'(done0), 160'd1);
        chk("s3_count", 160'(cnt0), 160'd0);
        chk("s3_slots", seq0, {160{1'b1}});
        Enter = 1'b0; OutReady = 1'b1;
        for (int k = 0; k < 4; k++) step();
        OutReady = 1'b0;

        // Overflow on the four-slot instance.
        Clear = 1'b1; step(); Clear = 1'b0;
        push(THREE, A); push(THREE, A);
        chk("s4_full", 160'(full2), 160'd1);
        chk("s4_ovf_before", 160'(ovf2), 160'd0);
        push(THREE, A);
        chk("s4_slots", {120'b0, seq2}, 160'({A, THREE, A, THREE}));
        chk("s4_overflow", 160'(ovf2), 160'd1);
        Clear = 1'b1; step(); Clear = 1'b0;
        push(THREE, A); push(THREE, INV); push(THREE, A);
        chk("s4b_count", 160'(cnt2), 160'd4);
        chk("s4b_overflow", 160'(ovf2), 160'd1);

        // Clear mid-drain, then Enter on an empty buffer.
        Clear = 1'b1; step(); Clear = 1'b0;
        push(A, THREE); push(THREE, A);
        Enter = 1'b1; step(); Enter = 1'b0;
        OutReady = 1'b1; step(); step();
        Clear = 1'b1; step(); Clear = 1'b0;
        chk("s5_valid", 160'(ov0), 160'd0);
        chk("s5_count", 160'(cnt0), 160'd0);
        chk("s5_nodone", 160'(done0), 160'd0);
        step();
        Enter = 1'b1; step(); Enter = 1'b0;
        chk("s5_empty_done", 160'(done0), 160'd1);
        chk("s5_empty_valid", 160'(ov0), 160'd0);
        step();
        chk("s5_done_once", 160'(done0), 160'd0);
        OutReady = 1'b0;

        // Reset while SentFlag is held high.
        FirstSeq = A; SecSeq = INV; SentFlag = 1'b1; Resetbar = 1'b0;
        step();
        Resetbar = 1'b1;
        step(); step();
        chk("s6_no_push", 160'(cnt0), 160'd0);
        SentFlag = 1'b0; step();
        SentFlag = 1'b1; step();
        chk("s6_push", 160'(cnt0), 160'd1);
        SentFlag = 1'b0; step();

        // Randomized traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            Resetbar = ($urandom_range(0, 199) != 0);
            Clear    = ($urandom_range(0, 59) == 0);
            SentFlag = 1'($urandom_range(0, 1));
            Enter    = ($urandom_range(0, 11) == 0);
            OutReady = ($urandom_range(0, 9) < 7);
            FirstSeq = pick();
            SecSeq   = pick();
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
